// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared definitions for the ccff chain loader: FSM state encoding, the
// CRC-16-CCITT constants and a single-bit CRC update helper.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial step of CRC-16-CCITT, MSB-first register, data bit XORed into
    // the feedback tap.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// ccff_crc16_serial
// Serial CRC-16-CCITT accumulator for the bits driven into the ccff chain.
// Ports:
//   prog_clk   - clock
//   pReset_n   - asynchronous active-low reset (register returns to CRC_INIT)
//   init       - reload CRC_INIT on the next edge
//   en         - fold bit_in into the CRC on the next edge
//   bit_in     - serial data bit
//   crc        - current CRC register
//   crc_next   - value the register takes on the next edge
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);

    // crc_next is exposed so the parent can judge the final CRC in the same
    // cycle that the last bit is folded in.
    always_comb begin
        crc_next = crc;
        if (init) begin
            crc_next = CRC_INIT;
        end else if (en) begin
            crc_next = crc16_step(crc, bit_in);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc <= CRC_INIT;
        end else begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader
// Streams bitstream words LSB-first into a switch-block ccff configuration
// chain of CHAIN_LEN bits, gating the chain clock through ccff_shift_en.
// Optional feature: define CCFF_LOADER_CRC_EN to check a CRC-16-CCITT of the
// shifted bits against expected_crc; otherwise crc_err is tied low.
// Ports:
//   prog_clk       - clock, all state changes on rising edge
//   pReset_n       - asynchronous active-low reset
//   start          - single-cycle load request (honoured in IDLE/DONE only)
//   bs_data        - bitstream word
//   bs_valid       - bs_data qualifier
//   bs_ready       - word accepted when bs_valid && bs_ready
//   ccff_head      - serial bit into the chain head (registered)
//   ccff_shift_en  - chain clock-gate enable (registered)
//   busy, done     - status
//   expected_crc   - golden CRC (used only with CCFF_LOADER_CRC_EN)
//   crc_err        - CRC mismatch flag, valid from DONE until next start
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    input  logic [15:0]       expected_crc,
    output logic              crc_err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

    state_t state, state_next;

    logic [CNT_W-1:0]  bit_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [WORD_W-1:0] shift_reg;

    logic start_ok;
    logic xfer;
    logic word_end;
    logic chain_end;

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign xfer      = (state == LOAD) && bs_valid;
    assign word_end  = (word_cnt == LAST_WBIT);
    assign chain_end = (bit_cnt == LAST_BIT);

    assign bs_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == SHIFT);
    assign done     = (state == DONE);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Chain end takes priority over word end so the remaining bits of the
    // final word are simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = LOAD;
            LOAD:    if (bs_valid) state_next = SHIFT;
            SHIFT: begin
                if (chain_end) begin
                    state_next = DONE;
                end else if (word_end) begin
                    state_next = LOAD;
                end
            end
            DONE:    if (start_ok) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // The serial outputs are computed one cycle ahead so that ccff_head and
    // ccff_shift_en are high exactly in the cycles the FSM sits in SHIFT.
    // bit 0 of a new word goes straight to ccff_head; the shift register
    // holds the bits still to come.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            bit_cnt       <= '0;
            word_cnt      <= '0;
            shift_reg     <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
        end else begin
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            if (start_ok) begin
                bit_cnt <= '0;
            end
            if (xfer) begin
                shift_reg     <= bs_data >> 1;
                word_cnt      <= '0;
                ccff_head     <= bs_data[0];
                ccff_shift_en <= 1'b1;
            end
            if (state == SHIFT) begin
                bit_cnt  <= bit_cnt + 1'b1;
                word_cnt <= word_cnt + 1'b1;
                if (state_next == SHIFT) begin
                    shift_reg     <= shift_reg >> 1;
                    ccff_head     <= shift_reg[0];
                    ccff_shift_en <= 1'b1;
                end
            end
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_next;

    ccff_crc16_serial u_crc (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .init     (start_ok),
        .en       (ccff_shift_en),
        .bit_in   (ccff_head),
        .crc      (crc),
        .crc_next (crc_next)
    );

    // The last bit is folded in on the same edge that enters DONE, so the
    // verdict is taken from crc_next rather than the register.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc_err <= 1'b0;
        end else if (start_ok) begin
            crc_err <= 1'b0;
        end else if ((state == SHIFT) && (state_next == DONE)) begin
            crc_err <= (crc_next != expected_crc);
        end
    end
`else
    logic unused_expected_crc;
    assign unused_expected_crc = ^expected_crc;
    assign crc_err = 1'b0;
`endif

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 48, giving the number of configuration bits in the downstream switch-block ccff chain.
REQ-002 SHALL have parameter WORD_W, default 32, giving the bitstream word width.
REQ-003 SHALL have port prog_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port pReset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a single-cycle request to begin a load.
REQ-006 SHALL have port bs_data, input, WORD_W, the bitstream word.
REQ-007 SHALL have port bs_valid, input, 1, qualifying bs_data.
REQ-008 SHALL have port bs_ready, output, 1; a word transfers when bs_valid && bs_ready.
REQ-009 SHALL have port ccff_head, output, 1, the serial bit driven into the chain head.
REQ-010 SHALL have port ccff_shift_en, output, 1, the enable for the external prog_clk gate; the chain shifts only when this is 1.
REQ-011 SHALL have ports busy (output, 1) and done (output, 1) as status.
REQ-012 SHALL have ports expected_crc (input, 16) and crc_err (output, 1).

Function
REQ-013 SHALL use FSM states IDLE, LOAD, SHIFT and DONE.
REQ-014 In IDLE or DONE, start SHALL clear bit_cnt and done and move the FSM to LOAD; start in LOAD or SHIFT SHALL be ignored.
REQ-015 LOAD SHALL assert bs_ready; on transfer it SHALL capture bs_data into the shift register and move to SHIFT; if bs_valid=0 it SHALL wait with ccff_shift_en=0.
REQ-016 SHIFT SHALL present the shift register LSB on ccff_head with ccff_shift_en=1 for exactly one cycle per bit, LSB first, and increment bit_cnt.
REQ-017 When all WORD_W bits of a word are shifted and bit_cnt<CHAIN_LEN, the FSM SHALL return to LOAD, giving exactly one bubble cycle (ccff_shift_en=0) per word.
REQ-018 When bit_cnt reaches CHAIN_LEN, the FSM SHALL enter DONE immediately, and the unshifted bits of the last word SHALL be discarded.
REQ-019 The total number of ccff_shift_en=1 cycles per load SHALL equal CHAIN_LEN exactly.
REQ-020 bit_cnt SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-021 busy SHALL be 1 in LOAD and SHIFT; done SHALL be 1 in DONE and remain 1 until the next accepted start.
REQ-022 ccff_head and ccff_shift_en SHALL be registered outputs; ccff_head SHALL be 0 whenever ccff_shift_en=0.

Reset
REQ-023 pReset_n=0 SHALL asynchronously force IDLE, with bs_ready, ccff_head, ccff_shift_en, busy, done and crc_err at 0 and bit_cnt at 0.
REQ-024 Reset during LOAD or SHIFT SHALL abandon the load with no further shift pulses; release SHALL be synchronous to prog_clk.

Configuration
REQ-025 Macro CCFF_LOADER_CRC_EN defined: a serial CRC-16-CCITT (polynomial 0x1021, init 0xFFFF) SHALL be updated with every bit shifted when ccff_shift_en=1, and the CRC register SHALL reset to the init value on accepted start.
REQ-026 Macro CCFF_LOADER_CRC_EN defined: on entry to DONE, crc_err SHALL be set to (crc != expected_crc) and held until the next start.
REQ-027 Macro CCFF_LOADER_CRC_EN undefined: no CRC logic SHALL exist, crc_err SHALL be tied to 0, and expected_crc SHALL be unused.

Structure
REQ-028 Package ccff_loader_pkg SHALL hold the state enum, CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
REQ-029 The CRC SHALL be implemented in sub-module ccff_crc16_serial, instantiated only under CCFF_LOADER_CRC_EN.

Verification
REQ-030 Defaults, bs_valid always 1, words 0xA5A5_0F0F and 0x0000_BEEF, start -> ccff_head sequence equals bits 0..31 then 0..15 LSB-first, 48 shift pulses, one bubble cycle, done=1.
REQ-031 Same as REQ-030 but bs_valid held low 5 cycles before word 2 -> ccff_shift_en=0 for 5+1 cycles, total pulses still 48.
REQ-032 start pulsed during SHIFT -> no effect; pulse count still 48.
REQ-033 pReset_n=0 after 20 shifts -> outputs immediately 0, no further pulses; new start after release -> full 48-pulse load.
REQ-034 Under CCFF_LOADER_CRC_EN, expected_crc set to the golden CRC -> crc_err=0; expected_crc with one bit flipped -> crc_err=1 at DONE.
REQ-035 CHAIN_LEN=32, WORD_W=32 -> one word, 32 pulses, no bubble, done one cycle after the last pulse.
